// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into SHORT / DOUBLE / LONG_START / REPEAT / LONG_END events,
// presented through a single-entry valid/ack register with a sticky overflow flag.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 500,
    parameter int unsigned DCLICK_CYCLES = 200,
    parameter int unsigned REPEAT_CYCLES = 100,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       evt_ack,
    input  logic       ovf_clr,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_ovf,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StPressed,
        StWaitSecond,
        StSecondPressed,
        StLongHeld
    } state_e;

    localparam logic [2:0] EvtNone      = 3'd0;
    localparam logic [2:0] EvtShort     = 3'd1;
    localparam logic [2:0] EvtDouble    = 3'd2;
    localparam logic [2:0] EvtLongStart = 3'd3;
    localparam logic [2:0] EvtRepeat    = 3'd4;
    localparam logic [2:0] EvtLongEnd   = 3'd5;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q;
    logic             rise, fall;
    logic             emit;
    logic [2:0]       emit_code;

    assign rise = btn_in & ~btn_q;
    assign fall = ~btn_in & btn_q;
    assign busy = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = EvtNone;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end
            end
            StPressed: begin
                if (fall) begin
                    state_d = StWaitSecond;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    state_d   = StLongHeld;
                    cnt_d     = '0;
                    emit      = 1'b1;
                    emit_code = EvtLongStart;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitSecond: begin
                if (rise) begin
                    state_d = StSecondPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DclickLast) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    emit      = 1'b1;
                    emit_code = EvtShort;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSecondPressed: begin
                // Hold time is irrelevant here; a second press always ends as DOUBLE.
                if (fall) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    emit      = 1'b1;
                    emit_code = EvtDouble;
                end
            end
            StLongHeld: begin
                if (fall) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    emit      = 1'b1;
                    emit_code = EvtLongEnd;
                end else if (cnt_q == RepeatLast) begin
                    cnt_d     = '0;
                    emit      = 1'b1;
                    emit_code = EvtRepeat;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            evt_valid <= 1'b0;
            evt_code  <= EvtNone;
            evt_ovf   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_in;
            // The FSM never waits on the consumer: an event that finds the slot full is dropped.
            if (emit && (!evt_valid || evt_ack)) begin
                evt_valid <= 1'b1;
                evt_code  <= emit_code;
            end else if (evt_ack) begin
                evt_valid <= 1'b0;
            end
            if (emit && evt_valid && !evt_ack) begin
                evt_ovf <= 1'b1;
            end else if (ovf_clr) begin
                evt_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, DCLICK=4, REPEAT=3: a vector table
// for single gestures plus hand-written long-press, overflow and reset sequences.
module tb_button_event_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_in;
    logic       evt_ack;
    logic       ovf_clr;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ovf;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       btn;
        logic       ack;
        logic       clr;
        logic       v;
        logic [2:0] code;
        logic       ovf;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    button_event_decoder #(
        .LONG_CYCLES  (8),
        .DCLICK_CYCLES(4),
        .REPEAT_CYCLES(3),
        .CNT_W        (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .evt_ack  (evt_ack),
        .ovf_clr  (ovf_clr),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ovf  (evt_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input logic b, input logic a, input logic c);
        btn_in  = b;
        evt_ack = a;
        ovf_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic v, input logic [2:0] c,
                         input logic o, input logic b);
        n_vec++;
        if (evt_valid !== v || evt_code !== c || evt_ovf !== o || busy !== b) begin
            n_err++;
            $display("FAIL %s: got valid=%b code=%0d ovf=%b busy=%b, want valid=%b code=%0d ovf=%b busy=%b",
                     name, evt_valid, evt_code, evt_ovf, busy, v, c, o, b);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic add(input logic b, input logic a, input logic c, input logic v,
                       input logic [2:0] code, input logic o, input logic bz);
        vecs.push_back('{b, a, c, v, code, o, bz});
    endtask

    int         ev_cyc[8];
    logic [2:0] ev_code[8];
    int         n_ev;
    logic       ack_next;
    logic       prev_valid;
    int         exp_cyc[4];
    int         exp_code[4];

    initial begin
        rst_n   = 1'b0;
        btn_in  = 1'b0;
        evt_ack = 1'b0;
        ovf_clr = 1'b0;
        #12;
        check("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with a stray ack: ignored.
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Short press: 3 high edges, SHORT 4 edges after release, held until ack.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        // Double click, no trailing SHORT.
        for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 2, 0, 0);
        add(0, 1, 0, 0, 2, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 2, 0, 0);
        // Held exactly 8 edges: release wins over long at cnt==7.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 2, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        // Held 9 edges: LONG_START; release with ack loads LONG_END directly.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 1, 3, 0, 1);
        add(0, 1, 0, 1, 5, 0, 0);
        add(0, 1, 0, 0, 5, 0, 0);
        // Second press at WAIT_SECOND cnt==3, held long: still DOUBLE.
        for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 5, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 5, 0, 1);
        for (int i = 0; i < 12; i++) add(1, 0, 0, 0, 5, 0, 1);
        add(0, 0, 0, 1, 2, 0, 0);
        add(0, 1, 0, 0, 2, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].btn, vecs[i].ack, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].ovf, vecs[i].busy);
        end

        // Long press of 16 edges, each event acked on the following edge.
        exp_cyc  = '{9, 12, 15, 17};
        exp_code = '{3, 4, 4, 5};
        n_ev       = 0;
        ack_next   = 1'b0;
        prev_valid = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            logic a;
            a = ack_next;
            step(cyc <= 16, a, 1'b0);
            if (evt_valid && (a || !prev_valid) && n_ev < 8) begin
                ev_cyc[n_ev]  = cyc;
                ev_code[n_ev] = evt_code;
                n_ev++;
            end
            prev_valid = evt_valid;
            ack_next   = evt_valid;
        end
        check_int("long_event_count", n_ev, 4);
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("long_ev%0d_cycle", i), (i < n_ev) ? ev_cyc[i] : -1, exp_cyc[i]);
            check_int($sformatf("long_ev%0d_code", i), (i < n_ev) ? int'(ev_code[i]) : -1,
                      exp_code[i]);
        end
        check("long_done", 1'b0, 3'd5, 1'b0, 1'b0);

        // Overflow: never ack; clear coinciding with a drop loses to the set.
        for (int cyc = 1; cyc <= 15; cyc++) begin
            step(1'b1, 1'b0, cyc == 15);
            if (cyc == 9)  check("ovf_long_start", 1'b1, 3'd3, 1'b0, 1'b1);
            if (cyc == 12) check("ovf_first_drop", 1'b1, 3'd3, 1'b1, 1'b1);
            if (cyc == 15) check("ovf_set_beats_clr", 1'b1, 3'd3, 1'b1, 1'b1);
        end
        step(1'b1, 1'b0, 1'b1);
        check("ovf_cleared", 1'b1, 3'd3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("ovf_ack_long_end", 1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("ovf_final_ack", 1'b0, 3'd5, 1'b0, 1'b0);

        // Reset asserted in LONG_HELD with a pending event and overflow set.
        for (int cyc = 1; cyc <= 12; cyc++) step(1'b1, 1'b0, 1'b0);
        check("pre_reset", 1'b1, 3'd3, 1'b1, 1'b1);
        #2;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        #1;
        check("async_reset", 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("in_reset", 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("post_reset%0d", cyc), 1'b0, 3'd0, 1'b0, 1'b0);
        end

        // Button already held at reset release is a rise on the first edge.
        rst_n  = 1'b0;
        btn_in = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check("held_rise", 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("held_wait%0d", i), 1'b0, 3'd0, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        check("held_short", 1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("held_ack", 1'b0, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 500: number of held cycles after the press edge before a long press is declared; SHALL be >=2.
REQ-002 Parameter DCLICK_CYCLES, default 200: maximum number of low cycles between a short release and a second press; SHALL be >=2.
REQ-003 Parameter REPEAT_CYCLES, default 100: period of REPEAT events while a long press is held; SHALL be >=2.
REQ-004 Parameter CNT_W, default 16: counter width; each of the three cycle parameters SHALL fit in CNT_W bits.
REQ-005 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 btn_in  input  1  debounced button level, synchronous to clk, 1=pressed.
REQ-008 evt_ack  input  1  consumer accepts the current event.
REQ-009 ovf_clr  input  1  clears evt_ovf.
REQ-010 evt_valid  output  1  an event is pending in evt_code.
REQ-011 evt_code  output  3  event type: 1=SHORT, 2=DOUBLE, 3=LONG_START, 4=REPEAT, 5=LONG_END; 0 and 6-7 are unused.
REQ-012 evt_ovf  output  1  sticky flag: an event was dropped.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 btn_q SHALL be a registered copy of btn_in; rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
REQ-015 FSM states SHALL be IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED, LONG_HELD, with one shared counter cnt.
REQ-016 Every transition listed below SHALL load cnt=0; every other edge spent in PRESSED, WAIT_SECOND or LONG_HELD SHALL increment cnt.
REQ-017 IDLE: on rise, go to PRESSED.
REQ-018 PRESSED: on fall, go to WAIT_SECOND; otherwise, when cnt==LONG_CYCLES-1, go to LONG_HELD and emit LONG_START; fall SHALL take precedence at the same edge.
REQ-019 WAIT_SECOND: on rise, go to SECOND_PRESSED; otherwise, when cnt==DCLICK_CYCLES-1, go to IDLE and emit SHORT; rise SHALL take precedence at the same edge.
REQ-020 SECOND_PRESSED: on fall, go to IDLE and emit DOUBLE, regardless of how long the button was held; cnt is not used in this state.
REQ-021 LONG_HELD: on fall, go to IDLE and emit LONG_END; otherwise, when cnt==REPEAT_CYCLES-1, emit REPEAT and load cnt=0; fall SHALL take precedence at the same edge.
REQ-022 Emitting an event SHALL register evt_code and set evt_valid at the same clock edge as the state transition, so the event is visible one cycle after the causing btn_in sample.
REQ-023 evt_valid and evt_code SHALL hold until a cycle in which evt_ack=1; at that edge evt_valid SHALL clear unless a new event is emitted at the same edge.
REQ-024 Emit at the same edge as evt_ack=1: the new event SHALL load and evt_valid SHALL stay 1.
REQ-025 Emit while evt_valid=1 and evt_ack=0: the new event SHALL be dropped, the pending event kept, and evt_ovf set.
REQ-026 evt_ack while evt_valid=0 SHALL be ignored.
REQ-027 evt_ovf SHALL clear on ovf_clr=1; if an overflow occurs at the same edge, set SHALL take precedence over clear.
REQ-028 The FSM SHALL never stall on the handshake; event timing depends only on btn_in.

Reset
REQ-029 While rst_n=0: state=IDLE, cnt=0, btn_q=0, evt_valid=0, evt_code=0, evt_ovf=0, busy=0.
REQ-030 Reset mid-operation SHALL abort the gesture with no event emitted.
REQ-031 A button already held high at reset release SHALL be seen as a rise on the first edge (btn_q=0).

Verification (LONG_CYCLES=8, DCLICK_CYCLES=4, REPEAT_CYCLES=3)
REQ-032 Short press: btn_in high 3 edges, then low -> exactly one SHORT (code 1), appearing 4 edges after the release edge; busy returns to 0.
REQ-033 Double click: high 2 edges, low 2 edges, high 2 edges, low -> one DOUBLE (code 2) one cycle after the second release, and no SHORT.
REQ-034 Long press with repeat: high 16 edges, ack every event within 1 cycle -> LONG_START, REPEAT, REPEAT, then LONG_END one cycle after release; REPEAT events are 3 cycles apart.
REQ-035 Boundary: high exactly 8 edges (release at cnt==7) -> SHORT path; high 9 edges -> LONG_START; rise at WAIT_SECOND cnt==3 -> SECOND_PRESSED.
REQ-036 Overflow: never ack during the long press from REQ-034 -> evt_code stays 3, evt_ovf=1; ovf_clr then clears evt_ovf; an ack coincident with LONG_END loads code 5.
REQ-037 Reset asserted in LONG_HELD with evt_valid=1 -> all outputs 0 immediately; no event after release while btn_in is held low.
